macc_job_sched: RTL
===================

Name: macc_job_sched

Overview:
- Schedules dot-product jobs from NREQ requesters onto the single shared MACC datapath, round-robin, one job at a time.
- Streams each job's operand pairs into the datapath and clears the accumulator on the first pair.
- Waits out the datapath latency, then returns the 64-bit result with the requester ID over a valid/ready response port.
- Sits between the requester stream interfaces and the MACC instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LEN_W, 8, job length field width; max job = 2^LEN_W-1 pairs.
- MACC_LAT, 2, cycles from an operand pair presented at the MACC inputs until `macc_result` reflects it.
- TIMEOUT_CYC, 64, stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  job request per requester; held until granted.
- req_len  in  NREQ*LEN_W  job length per requester; slot i at [i*LEN_W +: LEN_W].
- req_grant  out  NREQ  one-hot, 1-cycle pulse; the job is accepted on this cycle.
- op_valid  in  NREQ  operand pair valid per requester.
- op_a  in  NREQ*32  operand A per requester.
- op_b  in  NREQ*32  operand B per requester.
- op_ready  out  NREQ  operand accepted; only the granted requester, only in STREAM.
- macc_a  out  32  datapath operand A.
- macc_b  out  32  datapath operand B.
- macc_acc_en  out  1  datapath restart strobe; 1 = discard old accumulation.
- macc_result  in  64  datapath result.
- res_valid  out  1  result available.
- res_data  out  64  job result.
- res_id  out  $clog2(NREQ)  requester index of the result.
- res_err  out  1  job aborted (timeout); 0 unless the feature is enabled.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0. Reset mid-job abandons the job silently; no response is produced.
- Datapath semantics, per accepted pair: product = a & b; result = (first ? 0 : result) ^ product.
- Idle/bubble cycles: drive macc_a = macc_b = 0 and macc_acc_en = 0. This leaves the result unchanged.
- IDLE:
  - If any req_valid is set, the round-robin pick starts from (last winner + 1) mod NREQ.
  - Pulse req_grant, latch the ID, latch len into a down-counter, set the first flag.
  - If len = 0, go to RESP with res_data = 0 and do not touch the datapath. Otherwise go to STREAM.
- STREAM:
  - op_ready[id] = 1.
  - On op_valid[id] & op_ready[id]: macc_a/macc_b = op_a/op_b of id (combinational pass-through), macc_acc_en = first flag, then clear first and decrement the counter.
  - Stalls (op_valid low) insert bubbles.
  - After the last pair, go to DRAIN.
- DRAIN: wait exactly MACC_LAT cycles from the last pair's issue cycle. Then capture macc_result into res_data and go to RESP.
- RESP:
  - res_valid = 1, with res_data/res_id/res_err stable until res_ready.
  - On handshake: return to IDLE, and update the RR pointer to the served ID.
  - A new grant occurs no earlier than the cycle after the handshake.
- Simultaneous requests: exactly one grant per job. A requester that drops req_valid before grant is not served.
- A second job from the same requester is not granted while other requesters are waiting (strict RR).
- Job length up to 2^LEN_W-1. The counter is LEN_W bits and must not wrap.

Optional Feature:
- Macro: MACC_JOB_SCHED_TIMEOUT_EN.
- Defined:
  - In STREAM, a stall counter counts consecutive cycles with op_valid[id] low and resets on each accepted pair.
  - At TIMEOUT_CYC it aborts: skip DRAIN, go to RESP with res_err = 1 and res_data = 0.
  - The datapath is left as-is; the next job's first pair clears it.
- Undefined: no counter logic, res_err tied 0, stalls wait indefinitely.

Decomposition:
- Package macc_sched_pkg: state enum (IDLE, STREAM, DRAIN, RESP), MACC_LAT default, operand/result width constants (32/64).
- Sub-module macc_rr_arb: NREQ-wide round-robin arbiter with pointer update on an accept strobe. Reused elsewhere for MACC sharing.

Test Plan:
- Single job from requester 0, len = 3, pairs (0xFF,0x0F), (0xF0,0xFF), (0x3,0x1) back-to-back -> macc_acc_en high on the first pair only; res_data = 0xFE, res_id = 0, res_valid MACC_LAT cycles after the last pair.
- Both requesters assert together, each len = 1: req 0 pair (0xF0,0x3C), req 1 pair (0xFFFF,0x00FF) -> grant order 0 then 1; results 0x30 then 0xFF; the second result must not include the first (clear works).
- Len = 3 job with 5-cycle gaps of op_valid low between pairs -> macc_a/macc_b = 0 during gaps; result identical to the back-to-back case (0xFE).
- len = 0 request -> grant, res_valid next cycle with res_data = 0, no macc_acc_en pulse.
- res_ready held low 10 cycles -> res_* stable; no new grant while a pending req_valid is waiting. Assert rst_n low mid-STREAM -> all outputs 0 and no response after release.
- With MACC_JOB_SCHED_TIMEOUT_EN, TIMEOUT_CYC = 8: len = 2 job, one pair then op_valid low 8 cycles -> res_err = 1, res_data = 0; the next job returns a correct result.

Source files
------------

// File: rtl/macc_sched_pkg.sv
// macc_sched_pkg: shared scheduler state encoding and datapath width constants.
package macc_sched_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESP} state_t;
  localparam int MACC_LAT_DEF = 2;
  localparam int OP_W = 32;
  localparam int RES_W = 64;
endpackage

// File: rtl/macc_rr_arb.sv
// macc_rr_arb: N-way round-robin arbiter; search starts at ptr, ptr moves past the winner on upd.
module macc_rr_arb #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd,
  input  logic [IW-1:0] upd_id,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);
  logic [IW-1:0] ptr;
  int j;
  // descending scan so the candidate closest to ptr is assigned last and wins
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        gnt_id = IW'(j);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (upd) ptr <= (upd_id == IW'(N - 1)) ? '0 : upd_id + 1'b1;
endmodule

// File: rtl/macc_job_sched.sv
// macc_job_sched: round-robin dot-product job scheduler in front of one shared MACC datapath.
// Optional stall timeout abort: define MACC_JOB_SCHED_TIMEOUT_EN.
module macc_job_sched
  import macc_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LEN_W = 8,
  parameter int MACC_LAT = MACC_LAT_DEF,
  parameter int TIMEOUT_CYC = 64,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        req_grant,
  input  logic [NREQ-1:0]        op_valid,
  input  logic [NREQ*OP_W-1:0]   op_a,
  input  logic [NREQ*OP_W-1:0]   op_b,
  output logic [NREQ-1:0]        op_ready,
  output logic [OP_W-1:0]        macc_a,
  output logic [OP_W-1:0]        macc_b,
  output logic                   macc_acc_en,
  input  logic [RES_W-1:0]       macc_result,
  output logic                   res_valid,
  output logic [RES_W-1:0]       res_data,
  output logic [IW-1:0]          res_id,
  output logic                   res_err,
  input  logic                   res_ready
);
  localparam int DW = $clog2(MACC_LAT + 1);
  state_t state, state_nx;
  logic [IW-1:0] id, gnt_id;
  logic [NREQ-1:0] gnt;
  logic [LEN_W-1:0] cnt, len;
  logic [DW-1:0] dcnt;
  logic [RES_W-1:0] res_q;
  logic first, any, grant, fire, hs, to;
  macc_rr_arb #(.N(NREQ)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .upd(hs), .upd_id(id),
    .gnt(gnt), .gnt_id(gnt_id), .any(any)
  );
  assign len = req_len[gnt_id*LEN_W +: LEN_W];
  assign grant = (state == IDLE) && any;
  assign fire = (state == STREAM) && op_valid[id];
  assign hs = res_valid && res_ready;
  assign req_grant = grant ? gnt : '0;
  assign op_ready = (state == STREAM) ? NREQ'(1) << id : '0;
  assign macc_a = fire ? op_a[id*OP_W +: OP_W] : '0;
  assign macc_b = fire ? op_b[id*OP_W +: OP_W] : '0;
  assign macc_acc_en = fire && first;
  assign res_valid = (state == RESP);
  assign res_data = res_valid ? res_q : '0;
  assign res_id = res_valid ? id : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = !any ? IDLE : (len == '0) ? RESP : STREAM;
      STREAM: state_nx = (fire && cnt == LEN_W'(1)) ? DRAIN : to ? RESP : STREAM;
      DRAIN:  state_nx = (dcnt == DW'(MACC_LAT - 1)) ? RESP : DRAIN;
      RESP:   state_nx = hs ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      id <= '0;
      cnt <= '0;
      first <= 1'b0;
      dcnt <= '0;
      res_q <= '0;
    end else begin
      state <= state_nx;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (grant) begin
        id <= gnt_id;
        cnt <= len;
        first <= 1'b1;
        res_q <= '0;
      end
      if (fire) begin
        first <= 1'b0;
        cnt <= cnt - 1'b1;
      end
      if (state == DRAIN && state_nx == RESP) res_q <= macc_result;
    end
`ifdef MACC_JOB_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall;
  logic err_q;
  // res_q is cleared at grant and only loaded from DRAIN, so an abort already reports 0
  assign to = (state == STREAM) && !op_valid[id] && (stall == SW'(TIMEOUT_CYC - 1));
  assign res_err = res_valid && err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall <= '0;
      err_q <= 1'b0;
    end else begin
      stall <= (state == STREAM && !op_valid[id]) ? stall + 1'b1 : '0;
      if (grant) err_q <= 1'b0;
      else if (to) err_q <= 1'b1;
    end
`else
  assign to = 1'b0;
  assign res_err = 1'b0;
`endif
endmodule
